// File: rtl/xadc_drp_sampler.sv
// XADC DRP sampler: programs the single-channel config register on a channel select,
// then reads that channel on every end-of-conversion. Optional DRDY watchdog: XADC_DRP_TIMEOUT_EN.
module xadc_drp_sampler #(
    parameter logic [6:0]  CFG_REG_ADDR   = 7'h40,
    parameter logic [15:0] CFG_UPPER_BITS = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  set_addr_tdata,
    input  logic        set_addr_tvalid,
    output logic        set_addr_tready,
    output logic [31:0] xadc_tdata,
    output logic        xadc_tvalid,
    input  logic        xadc_tready,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        eoc
);

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        CFG_WAIT,
        WAIT_EOC,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t state, next_state;

    logic [4:0]  chan;
    logic        discard;
    logic        eoc_pend;
    logic        overrun;
    logic        res_timeout;
    logic [4:0]  res_chan;
    logic [15:0] res_do;

    logic set_hs;
    logic xadc_hs;
    logic busy;
    logic timeout_hit;

    logic take_chan;
    logic flush;
    logic capture;
    logic cap_timeout;
    logic set_discard;
    logic clr_discard;
    logic clr_pend;

    assign set_hs  = set_addr_tvalid & set_addr_tready;
    assign xadc_hs = xadc_tvalid & xadc_tready;
    assign busy    = (state == CFG_WR) || (state == CFG_WAIT) ||
                     (state == RD_REQ) || (state == RD_WAIT);

    assign xadc_tdata = {res_timeout, overrun, 9'd0, res_chan, res_do};

`ifdef XADC_DRP_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       unused_ok;

    // Counter restarts on every state change so each wait state gets a fresh budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (next_state != state) begin
            wait_cnt <= 8'd0;
        end else if ((state == CFG_WAIT) || (state == RD_WAIT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign timeout_hit = ((state == CFG_WAIT) || (state == RD_WAIT)) &&
                         (wait_cnt == TIMEOUT_LAST);
    assign unused_ok   = &{1'b0, set_addr_tdata[7:5]};
`else
    logic unused_ok;

    assign timeout_hit = 1'b0;
    assign unused_ok   = &{1'b0, set_addr_tdata[7:5], (TIMEOUT_CYCLES > 0)};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        take_chan   = 1'b0;
        flush       = 1'b0;
        capture     = 1'b0;
        cap_timeout = 1'b0;
        set_discard = 1'b0;
        clr_discard = 1'b0;
        clr_pend    = 1'b0;
        case (state)
            IDLE: begin
                if (set_hs) begin
                    take_chan  = 1'b1;
                    next_state = CFG_WR;
                end
            end
            CFG_WR: begin
                next_state = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (drp_drdy) begin
                    set_discard = 1'b1;
                    clr_pend    = 1'b1;
                    next_state  = WAIT_EOC;
                end else if (timeout_hit) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
            WAIT_EOC: begin
                if (set_hs) begin
                    take_chan  = 1'b1;
                    flush      = 1'b1;
                    clr_pend   = 1'b1;
                    next_state = CFG_WR;
                end else if (eoc || eoc_pend) begin
                    clr_pend = 1'b1;
                    // The first conversion after reconfiguration may still be for the old channel.
                    if (discard) begin
                        clr_discard = 1'b1;
                    end else begin
                        next_state = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                next_state = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_drdy) begin
                    capture    = 1'b1;
                    next_state = WAIT_EOC;
                end else if (timeout_hit) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    next_state  = WAIT_EOC;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan     <= 5'd0;
            discard  <= 1'b0;
            eoc_pend <= 1'b0;
        end else begin
            if (take_chan) begin
                chan <= set_addr_tdata[4:0];
            end
            if (set_discard) begin
                discard <= 1'b1;
            end else if (clr_discard) begin
                discard <= 1'b0;
            end
            // Only one conversion event is remembered while the DRP port is busy.
            if (clr_pend) begin
                eoc_pend <= 1'b0;
            end else if (eoc && busy) begin
                eoc_pend <= 1'b1;
            end
        end
    end

    // Result register: a capture overrides a same-cycle handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xadc_tvalid <= 1'b0;
            overrun     <= 1'b0;
            res_timeout <= 1'b0;
            res_chan    <= 5'd0;
            res_do      <= 16'd0;
        end else if (capture) begin
            xadc_tvalid <= 1'b1;
            overrun     <= xadc_tvalid & ~xadc_tready;
            res_timeout <= cap_timeout;
            res_chan    <= chan;
            res_do      <= cap_timeout ? 16'd0 : drp_do;
        end else if (flush || xadc_hs) begin
            xadc_tvalid <= 1'b0;
            overrun     <= 1'b0;
        end
    end

    // DRP request and ready outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set_addr_tready <= 1'b0;
            drp_den         <= 1'b0;
            drp_dwe         <= 1'b0;
            drp_daddr       <= 7'd0;
            drp_di          <= 16'd0;
        end else begin
            set_addr_tready <= (next_state == IDLE) || (next_state == WAIT_EOC);
            drp_den         <= (next_state == CFG_WR) || (next_state == RD_REQ);
            drp_dwe         <= (next_state == CFG_WR);
            if (take_chan) begin
                drp_daddr <= CFG_REG_ADDR;
                drp_di    <= (CFG_UPPER_BITS & 16'hFFE0) | {11'd0, set_addr_tdata[4:0]};
            end else if (next_state == RD_REQ) begin
                drp_daddr <= {2'b00, chan};
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for xadc_drp_sampler: scripted DRP responder, expected result words queued
// when the DRP response is driven and compared when the sampler publishes them.
module tb_xadc_drp_sampler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  set_addr_tdata = 8'd0;
    logic        set_addr_tvalid = 1'b0;
    logic        set_addr_tready;
    logic [31:0] xadc_tdata;
    logic        xadc_tvalid;
    logic        xadc_tready = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'd0;
    logic        drp_drdy = 1'b0;
    logic        eoc = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [4:0]  exp_chan = 5'd0;

    xadc_drp_sampler #(
        .CFG_REG_ADDR  (7'h40),
        .CFG_UPPER_BITS(16'h0000),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .set_addr_tdata (set_addr_tdata),
        .set_addr_tvalid(set_addr_tvalid),
        .set_addr_tready(set_addr_tready),
        .xadc_tdata     (xadc_tdata),
        .xadc_tvalid    (xadc_tvalid),
        .xadc_tready    (xadc_tready),
        .drp_daddr      (drp_daddr),
        .drp_den        (drp_den),
        .drp_dwe        (drp_dwe),
        .drp_di         (drp_di),
        .drp_do         (drp_do),
        .drp_drdy       (drp_drdy),
        .eoc            (eoc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({set_addr_tready, xadc_tvalid, drp_den, drp_dwe} !== 4'b0000 ||
            xadc_tdata !== 32'd0 || drp_daddr !== 7'd0 || drp_di !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b den=%b dwe=%b data=%h addr=%h di=%h, expected all zero",
                     set_addr_tready, xadc_tvalid, drp_den, drp_dwe, xadc_tdata, drp_daddr, drp_di);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (set_addr_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", set_addr_tready);
        end
    endtask

    task automatic do_config(input logic [7:0] sel, input bit expect_flush);
        set_addr_tdata  = sel;
        set_addr_tvalid = 1'b1;
        tick();
        set_addr_tvalid = 1'b0;
        checks++;
        if (drp_den !== 1'b1 || drp_dwe !== 1'b1 || drp_daddr !== 7'h40 ||
            drp_di !== {11'd0, sel[4:0]}) begin
            errors++;
            $display("FAIL cfg_write: den=%b dwe=%b addr=%h di=%h, expected 1 1 40 %h",
                     drp_den, drp_dwe, drp_daddr, drp_di, {11'd0, sel[4:0]});
        end
        checks++;
        if (set_addr_tready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_low: got %b expected 0", set_addr_tready);
        end
        if (expect_flush) begin
            checks++;
            if (xadc_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL rechan_flush: tvalid=%b expected 0", xadc_tvalid);
            end
        end
        tick();
        checks++;
        if (drp_den !== 1'b0) begin
            errors++;
            $display("FAIL cfg_den_pulse: den=%b expected 0 in wait", drp_den);
        end
        drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        checks++;
        if (set_addr_tready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_done_ready: got %b expected 1", set_addr_tready);
        end
        // first conversion after configuration is dropped
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        checks++;
        if (drp_den !== 1'b0) begin
            errors++;
            $display("FAIL discard_eoc: den=%b expected 0", drp_den);
        end
        exp_chan = sel[4:0];
    endtask

    task automatic do_read(input logic [15:0] data, input int delay,
                           input logic [31:0] expected, input bit hs_at_capture);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        checks++;
        if (drp_den !== 1'b1 || drp_dwe !== 1'b0 || drp_daddr !== {2'b00, exp_chan}) begin
            errors++;
            $display("FAIL rd_req: den=%b dwe=%b addr=%h, expected 1 0 %h",
                     drp_den, drp_dwe, drp_daddr, {2'b00, exp_chan});
        end
        repeat (delay) tick();
        drp_drdy = 1'b1;
        drp_do   = data;
        if (hs_at_capture) xadc_tready = 1'b1;
        exp_q.push_back(expected);
        tick();
        drp_drdy    = 1'b0;
        xadc_tready = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (xadc_tvalid !== 1'b1 || xadc_tdata !== got) begin
            errors++;
            $display("FAIL rd_result: tvalid=%b tdata=%h, expected 1 %h", xadc_tvalid, xadc_tdata, got);
        end
    endtask

    task automatic consume();
        xadc_tready = 1'b1;
        tick();
        xadc_tready = 1'b0;
        checks++;
        if (xadc_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL consume: tvalid=%b expected 0", xadc_tvalid);
        end
    endtask

    task automatic test_first_read();
        do_config(8'hE3, 1'b0);
        do_read(16'hABC0, 1, 32'h0003ABC0, 1'b0);
        consume();
    endtask

    task automatic test_overrun();
        do_read(16'h1111, 1, 32'h00031111, 1'b0);
        do_read(16'h2222, 2, 32'h40032222, 1'b0);
        consume();
        do_read(16'h3333, 1, 32'h00033333, 1'b0);
    endtask

    task automatic test_capture_and_handshake();
        do_read(16'h4444, 1, 32'h00034444, 1'b1);
        consume();
    endtask

    task automatic test_eoc_during_rd_wait();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        checks++;
        if (set_addr_tready !== 1'b0) begin
            errors++;
            $display("FAIL rdwait_ready_low: got %b expected 0", set_addr_tready);
        end
        repeat (3) tick();
        drp_drdy = 1'b1;
        drp_do   = 16'h5555;
        exp_q.push_back(32'h00035555);
        tick();
        drp_drdy = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (xadc_tvalid !== 1'b1 || xadc_tdata !== got) begin
            errors++;
            $display("FAIL pend_first: tvalid=%b tdata=%h, expected 1 %h", xadc_tvalid, xadc_tdata, got);
        end
        tick();
        checks++;
        if (drp_den !== 1'b1 || drp_dwe !== 1'b0 || drp_daddr !== 7'h03) begin
            errors++;
            $display("FAIL pend_reissue: den=%b dwe=%b addr=%h, expected 1 0 03", drp_den, drp_dwe, drp_daddr);
        end
        tick();
        drp_drdy = 1'b1;
        drp_do   = 16'h6666;
        exp_q.push_back(32'h40036666);
        tick();
        drp_drdy = 1'b0;
        got = exp_q.pop_front();
        checks++;
        if (xadc_tvalid !== 1'b1 || xadc_tdata !== got) begin
            errors++;
            $display("FAIL pend_second: tvalid=%b tdata=%h, expected 1 %h", xadc_tvalid, xadc_tdata, got);
        end
        consume();
    endtask

`ifdef XADC_DRP_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        exp_q.push_back(32'h80030000);
        n = 0;
        while (xadc_tvalid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        got = exp_q.pop_front();
        checks++;
        if (xadc_tvalid !== 1'b1 || xadc_tdata !== got || n != 21) begin
            errors++;
            $display("FAIL rd_timeout: tvalid=%b tdata=%h after %0d cycles, expected 1 %h after 21",
                     xadc_tvalid, xadc_tdata, n, got);
        end
        checks++;
        if (set_addr_tready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_back_to_wait: ready=%b expected 1", set_addr_tready);
        end
        consume();
    endtask
`endif

    task automatic test_rechan();
        do_read(16'h7777, 1, 32'h00037777, 1'b0);
        do_config(8'h10, 1'b1);
        do_read(16'h8888, 1, 32'h00108888, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({set_addr_tready, xadc_tvalid, drp_den, drp_dwe} !== 4'b0000 ||
            xadc_tdata !== 32'd0 || drp_daddr !== 7'd0 || drp_di !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: rdy=%b vld=%b den=%b dwe=%b data=%h addr=%h di=%h, expected all zero",
                     set_addr_tready, xadc_tvalid, drp_den, drp_dwe, xadc_tdata, drp_daddr, drp_di);
        end
        tick();
        reset    = 1'b0;
        drp_drdy = 1'b1;
        drp_do   = 16'hDEAD;
        tick();
        drp_drdy = 1'b0;
        tick();
        checks++;
        if (xadc_tvalid !== 1'b0 || drp_den !== 1'b0 || set_addr_tready !== 1'b1) begin
            errors++;
            $display("FAIL late_drdy_idle: vld=%b den=%b rdy=%b, expected 0 0 1",
                     xadc_tvalid, drp_den, set_addr_tready);
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_overrun();
        test_capture_and_handshake();
        test_eoc_during_rd_wait();
`ifdef XADC_DRP_TIMEOUT_EN
        test_timeout();
`endif
        test_rechan();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xadc_drp_sampler.md
# xadc_drp_sampler

Drives the XADC DRP port on behalf of the control register file. It accepts a channel-select stream (the XADC_SET_CHAN register write), reprograms the XADC single-channel configuration register, then samples that channel on every end-of-conversion. The latest sample is presented as a clear-on-read result stream (the XADC_DATA register read). It sits between the register file and the XADC primitive, which stays outside the block.

## Interface
Parameters:
- `CFG_REG_ADDR`, 7'h40: DRP address of the XADC configuration register 0.
- `CFG_UPPER_BITS`, 16'h0000: constant OR'd into the config write, bits [15:5] only; bits [4:0] are forced to the channel.
- `TIMEOUT_CYCLES`, 255: DRDY watchdog limit. Used only with `XADC_DRP_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `set_addr_tdata`, in, 8: channel select. Bits [4:0] are used; bits [7:5] are ignored.
- `set_addr_tvalid`, in, 1; `set_addr_tready`, out, 1: channel-select handshake.
- `xadc_tdata`, out, 32: result word `{timeout, overrun, 9'b0, chan[4:0], drp_do[15:0]}`.
- `xadc_tvalid`, out, 1; `xadc_tready`, in, 1: result handshake.
- `drp_daddr`, out, 7; `drp_den`, out, 1; `drp_dwe`, out, 1; `drp_di`, out, 16: DRP request.
- `drp_do`, in, 16; `drp_drdy`, in, 1: DRP response.
- `eoc`, in, 1: XADC end-of-conversion pulse.

## Operation
State machine:
- **IDLE**: no channel is configured. `set_addr_tready`=1. On a handshake: latch `chan`, go to CFG_WR.
- **CFG_WR**: one cycle. Drive `drp_den`=`drp_dwe`=1, `drp_daddr`=`CFG_REG_ADDR`, `drp_di`=`CFG_UPPER_BITS & 16'hFFE0 | chan`. Then go to CFG_WAIT.
- **CFG_WAIT**: wait for `drp_drdy`. Then set `discard`=1, clear `eoc_pend`, go to WAIT_EOC.
- **WAIT_EOC**: `set_addr_tready`=1. Checks in priority order:
  - A set_addr handshake latches the new `chan`, clears `xadc_tvalid`, `overrun` and `eoc_pend`, and goes to CFG_WR.
  - Otherwise, `eoc` or `eoc_pend` with `discard`=1 clears both `discard` and `eoc_pend`, and stays in WAIT_EOC.
  - Otherwise, `eoc` or `eoc_pend` goes to RD_REQ and clears `eoc_pend`.
- **RD_REQ**: one cycle. Drive `drp_den`=1, `drp_dwe`=0, `drp_daddr`=`{2'b0, chan}`. Then go to RD_WAIT.
- **RD_WAIT**: on `drp_drdy`, capture `drp_do` into the result register and go to WAIT_EOC.

Other rules:
- An `eoc` arriving in CFG_WR, CFG_WAIT, RD_REQ or RD_WAIT sets `eoc_pend`. Only one event is remembered; further events are dropped.
- `drp_den` and `drp_dwe` are high only in the request cycle. `drp_daddr` and `drp_di` hold their values otherwise.
- Result capture sets `xadc_tvalid`=1. If `xadc_tvalid` was already 1 and no handshake happens in the same cycle, `overrun`=1.
- The `overrun` bit is sticky until the next result handshake.
- A result handshake (`xadc_tvalid & xadc_tready`) clears `xadc_tvalid` and `overrun`.
- Capture and handshake in the same cycle: the capture wins. `xadc_tvalid` stays 1 with the new data and `overrun` stays 0.
- `xadc_tdata` holds stable while `xadc_tvalid`=1, except when overwritten by a capture.
- `set_addr_tready` is 0 in CFG_WR, CFG_WAIT, RD_REQ and RD_WAIT. A DRP transaction is never aborted by a channel change.

## Timing
- Reset values of all outputs are 0. This covers `set_addr_tready`, `xadc_tvalid`, `xadc_tdata`, `drp_den`, `drp_dwe`, `drp_daddr` and `drp_di`.
- State resets to IDLE. `chan`, `discard`, `eoc_pend` and `overrun` reset to 0.
- An assertion of `reset` mid-transaction abandons the DRP cycle immediately. Any late `drp_drdy` is ignored in IDLE.
- `set_addr_tready` is 1 from the first clock edge after reset deassertion.
- Set_addr handshake at cycle N → `drp_den`/`drp_dwe` pulse at N+1.
- `eoc` seen in WAIT_EOC at cycle M → read `drp_den` pulse at M+1.
- `drp_drdy` at cycle K → `xadc_tvalid`=1 and data valid at K+1.
- Minimum eoc-to-`xadc_tvalid` latency is 3 cycles when DRDY returns in the cycle after DEN.

## Configuration
Macro `XADC_DRP_TIMEOUT_EN`.

When defined:
- An 8-bit (≥ clog2(`TIMEOUT_CYCLES`+1)) counter runs in CFG_WAIT and RD_WAIT. It resets on state entry.
- Timeout occurs when the counter reaches `TIMEOUT_CYCLES` without `drp_drdy`. Both cases publish a result with timeout=1 and `drp_do` field 0, following the normal capture/overrun rules:
  - In RD_WAIT, the FSM returns to WAIT_EOC.
  - In CFG_WAIT, the FSM goes to IDLE and `chan` is kept in the word.

When undefined:
- There is no counter. Both WAIT states wait indefinitely and bit 31 is always 0.

## Test plan
- Reset, then set_addr 8'hE3 → DRP write at 0x40 with `drp_di`=16'h0003 one cycle after the handshake, and bits [7:5] are ignored. The first `eoc` after DRDY is discarded. The second `eoc` gives a read at 0x03; `drp_do`=16'hABC0 yields `xadc_tdata`=32'h0003ABC0.
- Two `eoc` captures with `xadc_tready`=0 → second word has bit 30 set. A handshake clears `xadc_tvalid`, and the next capture has bit 30 = 0.
- Capture and `xadc_tready` in the same cycle → `xadc_tvalid` stays 1, new data is shown, and overrun=0.
- `eoc` during RD_WAIT (DRDY delayed 5 cycles) → a second read issues immediately after return to WAIT_EOC without a new `eoc`.
- New set_addr 0x10 while a result is pending → `xadc_tvalid` drops, config write of 16'h0010 follows, and subsequent reads use address 0x10.
- With `XADC_DRP_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, DRDY never returns in RD_WAIT → after 20 cycles `xadc_tdata`=32'h80030000 and the FSM is back in WAIT_EOC. Asserting `reset` mid-wait returns all outputs to 0.
